// File: rtl/draw_sequencer.sv
// Runs the enabled drawing engines in ascending channel order and muxes the active engine onto the VGA pixel port.
// Start/busy/done and plot gating are registered state decodes; pixel data is a combinational mux.
module draw_sequencer #(
  parameter  int N_CH  = 2,
  parameter  int X_W   = 8,
  parameter  int Y_W   = 7,
  parameter  int C_W   = 3,
  parameter  int CNT_W = 8,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic                  abort,
  input  logic                  loop,
  input  logic [N_CH-1:0]       ch_en,
  output logic [N_CH-1:0]       eng_start,
  input  logic [N_CH-1:0]       eng_done,
  input  logic [N_CH*X_W-1:0]   eng_x,
  input  logic [N_CH*Y_W-1:0]   eng_y,
  input  logic [N_CH*C_W-1:0]   eng_colour,
  input  logic [N_CH-1:0]       eng_plot,
  output logic [X_W-1:0]        vga_x,
  output logic [Y_W-1:0]        vga_y,
  output logic [C_W-1:0]        vga_colour,
  output logic                  vga_plot,
  output logic                  busy,
  output logic                  done,
  output logic [CH_W-1:0]       cur_ch,
  output logic [CNT_W-1:0]      pass_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   cur_q, cur_d;
  logic [N_CH-1:0]   en_q, en_d;
  logic [CNT_W-1:0]  pass_q, pass_d;

  logic [CH_W-1:0]   first_ch;
  logic [CH_W-1:0]   next_ch;
  logic              has_next;
  logic              cur_done;
  logic              cur_plot;

  // Lowest set bit of the live mask: where a new pass begins.
  always_comb begin
    first_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_en[i]) first_ch = CH_W'(i);
    end
  end

  // Next enabled channel above the current one within the latched mask.
  always_comb begin
    next_ch  = '0;
    has_next = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (en_q[i] && (i > int'(cur_q))) begin
        next_ch  = CH_W'(i);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    cur_done   = 1'b0;
    cur_plot   = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cur_q == CH_W'(i)) begin
        cur_done   = eng_done[i];
        cur_plot   = eng_plot[i];
        vga_x      = eng_x[i*X_W +: X_W];
        vga_y      = eng_y[i*Y_W +: Y_W];
        vga_colour = eng_colour[i*C_W +: C_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    en_d    = en_q;
    pass_d  = pass_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (go) begin
            en_d = ch_en;
            if (|ch_en) begin
              cur_d   = first_ch;
              state_d = S_RUN;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_RUN: begin
          if (cur_done) state_d = S_RELEASE;
        end
        S_RELEASE: begin
          if (!cur_done) begin
            if (has_next) begin
              cur_d   = next_ch;
              state_d = S_RUN;
            end else begin
              pass_d = pass_q + 1'b1;
              if (loop && (|ch_en)) begin
                en_d    = ch_en;
                cur_d   = first_ch;
                state_d = S_RUN;
              end else begin
                state_d = S_DONE;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      en_q    <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      en_q    <= en_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    eng_start = '0;
    if (state_q == S_RUN) begin
      for (int i = 0; i < N_CH; i++) begin
        if (cur_q == CH_W'(i)) eng_start[i] = 1'b1;
      end
    end
  end

  assign vga_plot   = (state_q == S_RUN) && cur_plot;
  assign busy       = (state_q == S_RUN) || (state_q == S_RELEASE);
  assign done       = (state_q == S_DONE);
  assign cur_ch     = cur_q;
  assign pass_count = pass_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Randomised bench for draw_sequencer: engines are played by the bench, expected run order comes from the enable mask.
module tb_draw_sequencer;
  localparam int N    = 4;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int CW   = 3;
  localparam int CNTW = 8;
  localparam int CHW  = 2;

  logic            clk = 1'b0;
  logic            rst, go, abort, loop;
  logic [N-1:0]    ch_en, eng_start, eng_done, eng_plot;
  logic [N*XW-1:0] eng_x;
  logic [N*YW-1:0] eng_y;
  logic [N*CW-1:0] eng_colour;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   vga_colour;
  logic            vga_plot, busy, done;
  logic [CHW-1:0]  cur_ch;
  logic [CNTW-1:0] pass_count;

  int checks = 0;
  int errors = 0;
  int exp_pass = 0;

  draw_sequencer #(.N_CH(N), .X_W(XW), .Y_W(YW), .C_W(CW), .CNT_W(CNTW)) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .loop(loop), .ch_en(ch_en),
    .eng_start(eng_start), .eng_done(eng_done), .eng_x(eng_x), .eng_y(eng_y),
    .eng_colour(eng_colour), .eng_plot(eng_plot), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .done(done),
    .cur_ch(cur_ch), .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_rand();
    eng_x      = $urandom;
    eng_y      = (N*YW)'($urandom);
    eng_colour = (N*CW)'($urandom);
    eng_plot   = N'($urandom);
  endtask

  function automatic int highest(input logic [N-1:0] m);
    int h = 0;
    for (int i = 0; i < N; i++) if (m[i]) h = i;
    return h;
  endfunction

  task automatic check_mux(input int ch, input bit running);
    #1;
    check("vga_x", 32'(vga_x), 32'(eng_x[ch*XW +: XW]));
    check("vga_y", 32'(vga_y), 32'(eng_y[ch*YW +: YW]));
    check("vga_colour", 32'(vga_colour), 32'(eng_colour[ch*CW +: CW]));
    check("vga_plot", 32'(vga_plot), running ? 32'(eng_plot[ch]) : 32'd0);
  endtask

  // Plays engine ch from the cycle its start is expected to be high until release is seen.
  task automatic serve_channel(input int ch);
    logic [N-1:0] oh;
    int r, d;
    oh = N'(1) << ch;
    r  = $urandom_range(0, 4);
    d  = $urandom_range(0, 3);
    check("start", 32'(eng_start), 32'(oh));
    check("busy_run", 32'(busy), 32'd1);
    check("cur_ch_run", 32'(cur_ch), 32'(ch));
    repeat (r) begin
      drive_rand();
      eng_plot = ~oh;
      if ($urandom_range(0, 1) == 1) eng_plot[ch] = 1'b1;
      check_mux(ch, 1'b1);
      @(negedge clk);
      check("start_hold", 32'(eng_start), 32'(oh));
    end
    drive_rand();
    eng_done[ch] = 1'b1;
    check_mux(ch, 1'b1);
    @(negedge clk);
    check("start_release", 32'(eng_start), 32'd0);
    check("busy_release", 32'(busy), 32'd1);
    drive_rand();
    eng_plot = '1;
    check_mux(ch, 1'b0);
    repeat (d) begin
      @(negedge clk);
      check("start_release_hold", 32'(eng_start), 32'd0);
    end
    eng_done[ch] = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_pass(input logic [N-1:0] mask, input bit chg, input logic [N-1:0] new_en);
    bit first;
    first = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        if (first && chg) ch_en = new_en;
        first = 1'b0;
        serve_channel(i);
      end
    end
    exp_pass = (exp_pass + 1) % (1 << CNTW);
    check("pass_count", 32'(pass_count), 32'(exp_pass));
  endtask

  task automatic check_done(input int last);
    check("done", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("start_done", 32'(eng_start), 32'd0);
    check("cur_ch_done", 32'(cur_ch), 32'(last));
    drive_rand();
    eng_plot = '1;
    check_mux(last, 1'b0);
  endtask

  task automatic pulse_go(input logic [N-1:0] mask);
    ch_en = mask;
    go    = 1'b1;
    @(negedge clk);
    go    = 1'b0;
  endtask

  initial begin
    logic [N-1:0] m;
    int passes, n;
    rst = 1'b1; go = 1'b0; abort = 1'b0; loop = 1'b0;
    ch_en = '0; eng_done = '0;
    drive_rand();
    eng_plot = '1;

    repeat (2) @(negedge clk);
    check("rst_start", 32'(eng_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cur_ch", 32'(cur_ch), 32'd0);
    check("rst_pass", 32'(pass_count), 32'd0);
    check_mux(0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_start", 32'(eng_start), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Two channels in order.
    pulse_go(4'b0011);
    run_pass(4'b0011, 1'b0, '0);
    check_done(1);

    // Disabled channels are skipped.
    pulse_go(4'b1010);
    run_pass(4'b1010, 1'b0, '0);
    check_done(3);

    // Empty mask goes straight to DONE.
    ch_en = '0;
    go    = 1'b1;
    @(negedge clk);
    go    = 1'b0;
    check("empty_done", 32'(done), 32'd1);
    check("empty_busy", 32'(busy), 32'd0);
    check("empty_start", 32'(eng_start), 32'd0);
    check("empty_pass", 32'(pass_count), 32'(exp_pass));
    check("empty_cur_ch", 32'(cur_ch), 32'd3);
    @(negedge clk);
    check("empty_start2", 32'(eng_start), 32'd0);

    // Loop with mask changed mid-pass: takes effect at the wrap.
    loop = 1'b1;
    pulse_go(4'b0011);
    run_pass(4'b0011, 1'b1, 4'b0010);
    loop = 1'b0;
    run_pass(4'b0010, 1'b0, '0);
    check_done(1);

    // Abort mid-run while engine 0 plots.
    pulse_go(4'b0011);
    check("abort_pre_start", 32'(eng_start), 32'd1);
    eng_plot = '1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_start", 32'(eng_start), 32'd0);
    check("abort_plot", 32'(vga_plot), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_pass", 32'(pass_count), 32'(exp_pass));
    @(negedge clk);
    check("abort_idle_start", 32'(eng_start), 32'd0);
    pulse_go(4'b0011);
    run_pass(4'b0011, 1'b0, '0);
    check_done(1);

    // go tied high: DONE lasts a single cycle.
    ch_en = 4'b0001;
    go    = 1'b1;
    @(negedge clk);
    run_pass(4'b0001, 1'b0, '0);
    check_done(0);
    @(negedge clk);
    go = 1'b0;
    run_pass(4'b0001, 1'b0, '0);
    check_done(0);

    // Random masks and pass counts.
    for (int it = 0; it < 15; it++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      passes = $urandom_range(1, 3);
      loop = (passes > 1);
      pulse_go(m);
      for (int p = 0; p < passes; p++) begin
        if (p == passes - 1) loop = 1'b0;
        run_pass(m, 1'b0, '0);
      end
      check_done(highest(m));
    end

    // Run enough single-channel loop passes to wrap the pass counter.
    n = (1 << CNTW) + 2 - exp_pass;
    loop = 1'b1;
    pulse_go(4'b0010);
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) loop = 1'b0;
      run_pass(4'b0010, 1'b0, '0);
    end
    check_done(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Parametrised sequencer that runs up to N_CH drawing engines (fill, circle, Reuleaux, …) one after another and multiplexes the active engine's plot stream onto a single VGA adapter pixel port. It sits between the drawing engines and `vga_adapter` in a task top level. It generalises the fixed "fillscreen then shape" hookup with:
- a per-channel enable mask
- a full start/done/release handshake per engine
- an optional continuous loop mode, abort, and pass counting

## Interface
Parameters:
- N_CH, 2, number of engine channels (1..16); channel 0 runs first
- X_W, 8, pixel x width
- Y_W, 7, pixel y width
- C_W, 3, colour width
- CNT_W, 8, width of pass counter

Ports (CH_W = max(1, $clog2(N_CH))):
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  synchronous, active-high reset
- go  in  1  request a run; sampled only in IDLE or DONE
- abort  in  1  synchronous abort; overrides go
- loop  in  1  1 = restart from first enabled channel after last; sampled at end of each pass
- ch_en  in  N_CH  channel enable mask; latched at go and at each loop wrap
- eng_start  out  N_CH  level start to each engine; at most one bit high
- eng_done  in  N_CH  level done from each engine
- eng_x  in  N_CH*X_W  flattened x, channel i at [i*X_W +: X_W]
- eng_y  in  N_CH*Y_W  flattened y
- eng_colour  in  N_CH*C_W  flattened colour
- eng_plot  in  N_CH  per-engine plot strobe
- vga_x  out  X_W  muxed x
- vga_y  out  Y_W  muxed y
- vga_colour  out  C_W  muxed colour
- vga_plot  out  1  muxed plot, gated
- busy  out  1  high in RUN or RELEASE
- done  out  1  high in DONE
- cur_ch  out  CH_W  index of active/last channel
- pass_count  out  CNT_W  completed passes since reset; wraps modulo 2^CNT_W

## Operation
States:
- IDLE
- RUN
- RELEASE
- DONE

Registers:
- state, cur_ch, en_q (latched mask), pass_count
- reset value of each: IDLE, 0, 0, 0

Transitions:
- IDLE/DONE, go=1, abort=0:
  - latch en_q <= ch_en
  - if ch_en != 0: cur_ch <= lowest set bit, go to RUN
  - else: go to DONE, pass_count unchanged
- RUN: eng_start[cur_ch]=1. When eng_done[cur_ch]=1, go to RELEASE.
- RELEASE: eng_start all 0. Wait until eng_done[cur_ch]=0, then pick the next channel:
  - if a higher-index en_q bit is set: cur_ch <= next such index, go to RUN
  - else pass complete, pass_count <= pass_count+1, then:
    - loop=1 and ch_en != 0: en_q <= ch_en, cur_ch <= lowest set bit, go to RUN
    - otherwise: go to DONE
- DONE: done=1; cur_ch holds the last channel run. A new go restarts as from IDLE.
- abort=1 in any state: go to IDLE next cycle, eng_start <= 0, pass_count unchanged. Not counted as a pass.
- rst dominates abort and go.

Output mux:
- vga_x/y/colour = channel cur_ch's slice in all states.
- vga_plot = eng_plot[cur_ch] only in RUN, else 0.
- Plot strobes from non-selected channels are ignored.

Enable mask:
- Changes to ch_en mid-pass have no effect until the next go or loop wrap.

## Timing
- eng_start, busy, done, vga_plot gating: registered state decode. vga_x/y/colour and the vga_plot data path: combinational from eng_* inputs.
- go sampled at edge k gives eng_start[first] high from cycle k+1.
- eng_done[i] high at edge k gives eng_start[i] low from cycle k+1 (RELEASE).
- Release is observed at edge m (eng_done[i]=0) gives the next eng_start high from cycle m+1. Minimum gap between engines is 1 cycle with start low.
- Done already low on entry to RELEASE: advance on the first RELEASE edge (1 dead cycle).
- pass_count increments on the same edge that leaves RELEASE for the last channel.
- go held high in DONE retriggers immediately: DONE lasts exactly 1 cycle per pass when go is tied high.
- Single channel enabled with loop=1: that engine is restarted each pass through RELEASE.
- rst: all outputs 0 the cycle after the reset edge, except vga_x/y/colour which follow channel 0.

## Test plan
- Reset: rst=1 for 2 cycles, then check eng_start=0, busy=0, done=0, cur_ch=0, pass_count=0, vga_plot=0.
- Two-channel run (N_CH=2, ch_en=2'b11, loop=0): pulse go. Check:
  - eng_start=01 until done[0]; start drops 1 cycle later
  - after done[0] falls, eng_start=10
  - after done[1] rises and falls, done=1 and pass_count=1
  - plots from channel 1 during channel 0's RUN never reach vga_plot
- Skip (N_CH=4, ch_en=4'b1010): pulse go. Engines start in order 1 then 3; eng_start[0] and eng_start[2] never assert; final cur_ch=3.
- Empty mask: ch_en=0, go=1. Next cycle done=1, busy=0, pass_count unchanged, eng_start=0 throughout.
- Loop with live mask change (ch_en=2'b11, loop=1): change ch_en to 2'b10 mid-pass. Check:
  - current pass still runs channel 1
  - next pass runs only channel 1
  - pass_count increments each pass and wraps 255→0 with CNT_W=8
- Abort mid-RUN (engine 0 plotting): assert abort for 1 cycle. Next cycle state IDLE, eng_start=0, vga_plot=0, pass_count unchanged; a new go restarts at channel 0.
